// File: rtl/sound_sequencer.sv
// Multi-channel event-driven tone sequencer: one-shot event strobes play fixed-pitch,
// fixed-length square or sawtooth tones on a DAC code, with priority retrigger and mute.
module sound_sequencer #(
  parameter int                           NUM_CH    = 4,
  parameter int                           DAC_WIDTH = 8,
  parameter int                           DIV_WIDTH = 16,
  parameter int                           DUR_WIDTH = 24,
  parameter logic [NUM_CH*DIV_WIDTH-1:0]  CH_DIV    = {NUM_CH{16'd25000}},
  parameter logic [NUM_CH*DUR_WIDTH-1:0]  CH_DUR    = {NUM_CH{24'd5000000}},
  parameter int                           WAVE_SAW  = 0,
  parameter logic [DAC_WIDTH-1:0]         AMPLITUDE = {DAC_WIDTH{1'b1}},
  localparam int                          AW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button_i,
  input  logic [NUM_CH-1:0]    event_i,
  output logic [DAC_WIDTH-1:0] soundOut,
  output logic                 busy_o,
  output logic [AW-1:0]        active_ch_o,
  output logic                 muted_o
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t                 state_q;
  logic [NUM_CH-1:0]      ev_prev_q;
  logic                   btn_prev_q;
  logic [DAC_WIDTH-1:0]   sound_q;
  logic                   busy_q;
  logic [AW-1:0]          active_q;
  logic                   muted_q;
  logic [DIV_WIDTH-1:0]   div_cnt_q;
  logic [DUR_WIDTH-1:0]   dur_cnt_q;

  logic [NUM_CH-1:0]      ev_pulse;
  logic                   btn_pulse;
  logic                   any_pulse;
  logic [AW-1:0]          winner;
  logic [DIV_WIDTH-1:0]   cur_div;
  logic [DUR_WIDTH-1:0]   cur_dur;
  logic [DIV_WIDTH-1:0]   div_last;
  logic [DUR_WIDTH-1:0]   dur_last;
  logic                   start_ok;

  assign ev_pulse  = event_i & ~ev_prev_q;
  assign btn_pulse = button_i & ~btn_prev_q;
  assign any_pulse = |ev_pulse;

  // Descending scan so the lowest-index pulsing channel is the final assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ev_pulse[i]) winner = AW'(i);
    end
  end

  always_comb begin
    cur_div = '0;
    cur_dur = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_q == AW'(i)) begin
        cur_div = CH_DIV[i*DIV_WIDTH +: DIV_WIDTH];
        cur_dur = CH_DUR[i*DUR_WIDTH +: DUR_WIDTH];
      end
    end
  end

  // A configured value of 0 behaves like 1, so its terminal count is also 0.
  assign div_last = (cur_div == '0) ? '0 : cur_div - DIV_WIDTH'(1);
  assign dur_last = (cur_dur == '0) ? '0 : cur_dur - DUR_WIDTH'(1);

  assign start_ok = any_pulse && !muted_q && ((state_q == IDLE) || (winner <= active_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ev_prev_q  <= '0;
      btn_prev_q <= 1'b0;
      sound_q    <= '0;
      busy_q     <= 1'b0;
      active_q   <= '0;
      muted_q    <= 1'b0;
      div_cnt_q  <= '0;
      dur_cnt_q  <= '0;
    end else begin
      ev_prev_q  <= event_i;
      btn_prev_q <= button_i;
      if (btn_pulse) begin
        // Mute or unmute always silences and swallows any same-cycle event.
        muted_q   <= ~muted_q;
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        sound_q   <= '0;
        div_cnt_q <= '0;
        dur_cnt_q <= '0;
      end else if (start_ok) begin
        state_q   <= PLAY;
        busy_q    <= 1'b1;
        active_q  <= winner;
        div_cnt_q <= '0;
        dur_cnt_q <= '0;
        sound_q   <= (WAVE_SAW != 0) ? '0 : AMPLITUDE;
      end else if (state_q == PLAY) begin
        if (dur_cnt_q == dur_last) begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          sound_q   <= '0;
          div_cnt_q <= '0;
          dur_cnt_q <= '0;
        end else begin
          dur_cnt_q <= dur_cnt_q + DUR_WIDTH'(1);
          if (div_cnt_q == div_last) begin
            div_cnt_q <= '0;
            if (WAVE_SAW != 0) sound_q <= sound_q + DAC_WIDTH'(1);
            else               sound_q <= (sound_q == AMPLITUDE) ? '0 : AMPLITUDE;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
          end
        end
      end
    end
  end

  assign soundOut    = sound_q;
  assign busy_o      = busy_q;
  assign active_ch_o = active_q;
  assign muted_o     = muted_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: three builds (square, sawtooth, zero period/duration) share
// one stimulus stream; a time-based tone model predicts every cycle of every build.
module tb_sound_sequencer;
  localparam int W = 11;  // {soundOut[7:0], busy, active_ch, muted}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [1:0] ev  = 2'b00;

  logic [7:0] snd  [3];
  logic       busy [3];
  logic       act  [3];
  logic       mut  [3];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  always #5 clk = ~clk;

  sound_sequencer #(
    .NUM_CH(2), .DAC_WIDTH(8), .DIV_WIDTH(16), .DUR_WIDTH(24),
    .CH_DIV({16'd3, 16'd2}), .CH_DUR({24'd40, 24'd20}),
    .WAVE_SAW(0), .AMPLITUDE(8'hFF)
  ) dut_sq (
    .clk(clk), .rst(rst), .button_i(btn), .event_i(ev),
    .soundOut(snd[0]), .busy_o(busy[0]), .active_ch_o(act[0]), .muted_o(mut[0])
  );

  sound_sequencer #(
    .NUM_CH(2), .DAC_WIDTH(8), .DIV_WIDTH(16), .DUR_WIDTH(24),
    .CH_DIV({16'd3, 16'd1}), .CH_DUR({24'd40, 24'd300}),
    .WAVE_SAW(1), .AMPLITUDE(8'hFF)
  ) dut_saw (
    .clk(clk), .rst(rst), .button_i(btn), .event_i(ev),
    .soundOut(snd[1]), .busy_o(busy[1]), .active_ch_o(act[1]), .muted_o(mut[1])
  );

  sound_sequencer #(
    .NUM_CH(2), .DAC_WIDTH(8), .DIV_WIDTH(16), .DUR_WIDTH(24),
    .CH_DIV({16'd3, 16'd0}), .CH_DUR({24'd40, 24'd0}),
    .WAVE_SAW(0), .AMPLITUDE(8'hFF)
  ) dut_zero (
    .clk(clk), .rst(rst), .button_i(btn), .event_i(ev),
    .soundOut(snd[2]), .busy_o(busy[2]), .active_ch_o(act[2]), .muted_o(mut[2])
  );

  // Build configurations, indexed [build][channel].
  int cfg_div [3][2] = '{'{2, 3}, '{1, 3}, '{0, 3}};
  int cfg_dur [3][2] = '{'{20, 40}, '{300, 40}, '{0, 40}};
  bit cfg_saw [3]    = '{1'b0, 1'b1, 1'b0};

  // Model: a tone is "started at elapsed time 0 on channel ch"; output follows from elapsed time.
  bit         m_play [3];
  int         m_ch   [3];
  int         m_t    [3];
  bit         m_mute [3];
  logic [1:0] m_ev_prev;
  logic       m_btn_prev;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [W-1:0] expect_of(input int i);
    logic [7:0] s;
    int k;
    s = 8'h00;
    if (m_play[i]) begin
      k = m_t[i] / eff(cfg_div[i][m_ch[i]]);
      if (cfg_saw[i]) s = 8'(k % 256);
      else            s = ((k % 2) == 0) ? 8'hFF : 8'h00;
    end
    return {s, m_play[i], 1'(m_ch[i]), m_mute[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_play[i] = 1'b0;
      m_ch[i]   = 0;
      m_t[i]    = 0;
      m_mute[i] = 1'b0;
    end
    m_ev_prev  = 2'b00;
    m_btn_prev = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] e, input logic b);
    logic [1:0] p;
    logic       bp;
    int         w;
    p  = e & ~m_ev_prev;
    bp = b & ~m_btn_prev;
    w  = p[0] ? 0 : 1;
    for (int i = 0; i < 3; i++) begin
      if (bp) begin
        m_mute[i] = !m_mute[i];
        m_play[i] = 1'b0;
      end else if (!m_mute[i] && (p != 2'b00) && (!m_play[i] || w <= m_ch[i])) begin
        m_play[i] = 1'b1;
        m_ch[i]   = w;
        m_t[i]    = 0;
      end else if (m_play[i]) begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] >= eff(cfg_dur[i][m_ch[i]])) m_play[i] = 1'b0;
      end
    end
    m_ev_prev  = e;
    m_btn_prev = b;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Driver: one call per clock; inputs change on the falling edge, expectation is for the next rise.
  task automatic cycle(input logic [1:0] e, input logic b);
    @(negedge clk);
    ev  = e;
    btn = b;
    model_step(e, b);
    exp_q0.push_back(expect_of(0));
    exp_q1.push_back(expect_of(1));
    exp_q2.push_back(expect_of(2));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(2'b00, 1'b0);
  endtask

  task automatic check_cleared(input string name);
    for (int i = 0; i < 3; i++) check(name, {snd[i], busy[i], act[i], mut[i]}, '0);
  endtask

  // Monitor: outputs are valid every cycle; compare shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_q0.size() > 0) check("square",   {snd[0], busy[0], act[0], mut[0]}, exp_q0.pop_front());
    if (exp_q1.size() > 0) check("sawtooth", {snd[1], busy[1], act[1], mut[1]}, exp_q1.pop_front());
    if (exp_q2.size() > 0) check("zero_cfg", {snd[2], busy[2], act[2], mut[2]}, exp_q2.pop_front());
  end

  initial begin
    model_reset();
    #1;
    check_cleared("reset_initial");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Held level fires once.
    for (int k = 0; k < 5; k++) cycle(2'b01, 1'b0);
    idle(25);

    // Low-priority tone, preempted by ch0, ch1 rise ignored during ch0, then simultaneous rise.
    for (int k = 0; k < 10; k++) cycle(2'b10, 1'b0);
    cycle(2'b11, 1'b0);
    for (int k = 0; k < 3; k++) cycle(2'b01, 1'b0);
    for (int k = 0; k < 2; k++) cycle(2'b11, 1'b0);
    idle(45);
    for (int k = 0; k < 2; k++) cycle(2'b11, 1'b0);
    idle(45);

    // Mute during play, event while muted, unmute, play; then mute/unmute with same-cycle events.
    cycle(2'b01, 1'b0);
    idle(4);
    cycle(2'b00, 1'b1);
    idle(2);
    cycle(2'b01, 1'b0);
    idle(3);
    cycle(2'b00, 1'b1);
    idle(1);
    cycle(2'b01, 1'b0);
    idle(25);
    cycle(2'b01, 1'b1);
    idle(1);
    cycle(2'b01, 1'b1);
    idle(5);

    // Long ch0 tone covers the full sawtooth ramp and its wrap.
    cycle(2'b01, 1'b0);
    idle(310);

    // Asynchronous reset in the middle of a tone.
    cycle(2'b01, 1'b0);
    idle(5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_cleared("reset_mid_play");
    @(negedge clk);
    ev  = 2'b00;
    btn = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Random event levels and button presses.
    for (int k = 0; k < 2000; k++) begin
      logic [1:0] e;
      logic       b;
      e = ev;
      b = btn;
      if ($urandom_range(0, 5) == 0)  e[0] = ~e[0];
      if ($urandom_range(0, 5) == 0)  e[1] = ~e[1];
      if ($urandom_range(0, 39) == 0) b = ~b;
      cycle(e, b);
    end
    idle(3);

    @(posedge clk);
    #4;
    check("drain", W'(exp_q0.size() + exp_q1.size() + exp_q2.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
